// File: rtl/router_src_arbiter.sv
// Packet-granular round-robin arbiter sharing one router input among N_SRC sources; drops addr-3 packets.
// Latency: request to grant 1 cycle, byte path combinational while granted, error pulses 1 cycle after the byte.
// Backpressure: router busy is passed to the owner only; non-owners always see src_busy=1.
module router_src_arbiter #(
  parameter int N_SRC  = 3,
  parameter int DATA_W = 8
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [N_SRC-1:0]        src_pkt_valid,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [N_SRC-1:0]        src_busy,
  input  logic                    busy,
  output logic                    pkt_valid,
  output logic [DATA_W-1:0]       data_in,
  output logic [N_SRC-1:0]        grant,
  output logic                    len_err,
  output logic                    addr_err
);

  localparam int IW = $clog2(N_SRC);
  localparam int LW = DATA_W - 2;

  typedef enum logic [1:0] {IDLE, HDR, XFER, DROP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q, last_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]   len_q, len_d;
  logic            len_err_d, addr_err_d;

  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  int              cand;
  logic            sel_vld;
  logic [DATA_W-1:0] sel_dat;
  logic            own_rel;

  // Round-robin search: first asserted request after the last owner, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int i = 1; i <= N_SRC; i++) begin
      cand = (int'(last_q) + i) % N_SRC;
      if (!pick_vld && src_pkt_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(cand);
      end
    end
  end

  // Select the current owner's byte and valid.
  always_comb begin
    sel_vld = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (owner_q == IW'(i)) begin
        sel_vld = src_pkt_valid[i];
        sel_dat = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state, counters, router-side outputs and per-source stalls.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    len_err_d  = 1'b0;
    addr_err_d = 1'b0;
    pkt_valid  = 1'b0;
    data_in    = '0;
    own_rel    = 1'b0;
    src_busy   = '1;
    grant      = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          state_d = HDR;
        end
      end
      HDR: begin
        data_in   = sel_dat;
        // an addr-3 header is never shown to the router
        pkt_valid = sel_vld && (sel_dat[1:0] != 2'b11);
        own_rel   = !busy;
        if (!busy && sel_vld) begin
          if (sel_dat[1:0] == 2'b11) begin
            addr_err_d = 1'b1;
            state_d    = DROP;
          end else begin
            len_d   = sel_dat[DATA_W-1:2];
            cnt_d   = '0;
            state_d = XFER;
          end
        end
      end
      XFER: begin
        data_in   = sel_dat;
        pkt_valid = sel_vld;
        own_rel   = !busy;
        if (!busy) begin
          if (sel_vld) begin
            // count saturates at the header length; every extra byte flags
            if (cnt_q < len_q) cnt_d = cnt_q + LW'(1);
            else               len_err_d = 1'b1;
          end else begin
            if (cnt_q != len_q) len_err_d = 1'b1;
            last_d  = owner_q;
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        own_rel = 1'b1;
        if (!sel_vld) begin
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    for (int i = 0; i < N_SRC; i++) begin
      if (state_q != IDLE && owner_q == IW'(i)) begin
        grant[i]    = 1'b1;
        src_busy[i] = !own_rel;
      end
    end
  end

  // State, ownership, length tracking and registered error pulses.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      last_q   <= IW'(N_SRC - 1);
      cnt_q    <= '0;
      len_q    <= '0;
      len_err  <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      len_err  <= len_err_d;
      addr_err <= addr_err_d;
    end
  end

endmodule

// File: tb/tb_router_src_arbiter.sv
// Bench for router_src_arbiter: per-source byte queues feed the DUT, a packet-level model predicts every cycle.
// Latency: expectations are formed per cycle from queue fronts and the round-robin pointer.
// Backpressure: router busy is random or scripted; sources advance only when the model releases them.
module tb_router_src_arbiter;

  localparam int N  = 3;
  localparam int DW = 8;

  logic            clock = 1'b0;
  logic            resetn;
  logic [N-1:0]    src_pkt_valid;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]    src_busy;
  logic            busy;
  logic            pkt_valid;
  logic [DW-1:0]   data_in;
  logic [N-1:0]    grant;
  logic            len_err;
  logic            addr_err;

  router_src_arbiter #(.N_SRC(N), .DATA_W(DW)) dut (
    .clock(clock), .resetn(resetn),
    .src_pkt_valid(src_pkt_valid), .src_data(src_data), .src_busy(src_busy),
    .busy(busy), .pkt_valid(pkt_valid), .data_in(data_in), .grant(grant),
    .len_err(len_err), .addr_err(addr_err)
  );

  always #5 clock = ~clock;

  // One byte a source will present: fwd = router must see it, elen/eaddr = pulse expected after acceptance.
  typedef struct packed {
    bit        vld;
    logic [7:0] dat;
    bit        fwd;
    bit        elen;
    bit        eaddr;
    bit        is_par;
  } ent_t;

  ent_t srcq [N][$];
  bit   busy_plan [$];
  bit   busy_rand;
  bit   gate_en;
  int   m_owner, m_last;
  bit   m_drop, exp_len, exp_addr;
  int   nchk, nerr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_pkt(input int s, input int len, input int addr, input int npay, input bit fixed);
    ent_t e;
    logic [5:0] l6;
    logic [1:0] a2;
    l6 = len[5:0];
    a2 = addr[1:0];
    e = '{vld: 1'b1, dat: {l6, a2}, fwd: (addr != 3), elen: 1'b0, eaddr: (addr == 3), is_par: 1'b0};
    srcq[s].push_back(e);
    for (int k = 1; k <= npay; k++) begin
      e.dat   = fixed ? 8'(8'hA0 + k) : 8'($urandom);
      e.fwd   = (addr != 3);
      e.elen  = (addr != 3) && (k > len);
      e.eaddr = 1'b0;
      srcq[s].push_back(e);
    end
    e.vld    = 1'b0;
    e.dat    = fixed ? 8'h5A : 8'($urandom);
    e.fwd    = 1'b0;
    e.elen   = (addr != 3) && (npay < len);
    e.eaddr  = 1'b0;
    e.is_par = 1'b1;
    srcq[s].push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) srcq[i].delete();
    busy_plan.delete();
    m_owner  = -1;
    m_last   = N - 1;
    m_drop   = 1'b0;
    exp_len  = 1'b0;
    exp_addr = 1'b0;
  endtask

  task automatic cycle();
    logic [N-1:0] req, exp_g, exp_sb;
    ent_t e;
    bit   found;
    int   c;
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0) begin
        e = srcq[i][0];
        src_data[i*DW +: DW] = e.dat;
        src_pkt_valid[i] = e.vld && !(gate_en && m_owner != i && $urandom_range(0, 2) == 0);
      end else begin
        src_data[i*DW +: DW] = 8'($urandom);
        src_pkt_valid[i] = 1'b0;
      end
    end
    if (busy_plan.size() > 0) busy = busy_plan.pop_front();
    else                      busy = busy_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
    #1;
    exp_g = '0;
    exp_sb = '1;
    if (m_owner >= 0) begin
      exp_g[m_owner] = 1'b1;
      if (m_drop || !busy) exp_sb[m_owner] = 1'b0;
    end
    chk("grant", grant, exp_g);
    chk("src_busy", src_busy, exp_sb);
    chk("len_err", len_err, exp_len);
    chk("addr_err", addr_err, exp_addr);
    if (m_owner >= 0 && srcq[m_owner].size() > 0) begin
      e = srcq[m_owner][0];
      chk("pkt_valid", pkt_valid, e.vld && e.fwd);
      if (!m_drop && !e.eaddr) chk("data_in", data_in, e.dat);
    end else begin
      chk("pkt_valid_idle", pkt_valid, 0);
      chk("data_in_idle", data_in, 0);
    end
    // advance the model across the coming edge
    req = src_pkt_valid;
    exp_len = 1'b0;
    exp_addr = 1'b0;
    if (m_owner >= 0) begin
      if (srcq[m_owner].size() > 0 && (m_drop || !busy)) begin
        e = srcq[m_owner].pop_front();
        exp_len  = e.elen;
        exp_addr = e.eaddr;
        if (e.eaddr) m_drop = 1'b1;
        if (e.is_par) begin
          m_last  = m_owner;
          m_owner = -1;
          m_drop  = 1'b0;
        end
      end
    end else begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && req[c]) begin
          found   = 1'b1;
          m_owner = c;
        end
      end
    end
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((srcq[0].size() + srcq[1].size() + srcq[2].size() > 0 || m_owner >= 0) && n < limit) begin
      cycle();
      n++;
    end
    repeat (3) cycle();
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    src_pkt_valid = '0;
    src_data = '0;
    busy = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    busy_rand = 1'b0;
    gate_en = 1'b0;
    apply_reset();
    resetn = 1'b0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_pkt_valid", pkt_valid, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_src_busy", src_busy, 3'b111);
    chk("rst_len_err", len_err, 0);
    chk("rst_addr_err", addr_err, 0);
    @(negedge clock);
    resetn = 1'b1;

    // single packet 0x0C A1 A2 A3 P
    add_pkt(0, 3, 0, 3, 1'b1);
    drain(100);

    // three-way contention, then a fresh src0 request
    add_pkt(0, 2, 1, 2, 1'b0);
    add_pkt(1, 1, 2, 1, 1'b0);
    add_pkt(2, 3, 0, 3, 1'b0);
    drain(200);
    add_pkt(0, 1, 0, 1, 1'b0);
    drain(100);

    // router stall of 5 cycles after the 2nd payload byte
    add_pkt(1, 3, 0, 3, 1'b0);
    busy_plan = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    drain(100);

    // bad address 0x0B, then short and long packets
    add_pkt(1, 2, 3, 2, 1'b0);
    drain(100);
    add_pkt(2, 4, 0, 2, 1'b0);
    drain(100);
    add_pkt(0, 2, 0, 3, 1'b0);
    drain(100);

    // async reset in the middle of a payload
    add_pkt(0, 5, 0, 5, 1'b0);
    repeat (4) cycle();
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_pkt_valid", pkt_valid, 0);
    chk("arst_src_busy", src_busy, 3'b111);
    src_pkt_valid = '0;
    model_reset();
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    add_pkt(2, 1, 0, 1, 1'b0);
    add_pkt(1, 1, 0, 1, 1'b0);
    add_pkt(0, 1, 0, 1, 1'b0);
    repeat (2) cycle();
    chk("arst_src0_wins", grant, 3'b001);
    drain(200);

    // randomized traffic with random stalls and request gaps
    busy_rand = 1'b1;
    gate_en = 1'b1;
    for (int p = 0; p < 120; p++) begin
      int s, len, npay;
      s = $urandom_range(0, N - 1);
      len = $urandom_range(0, 5);
      npay = len + $urandom_range(0, 2) - 1;
      if (npay < 0) npay = 0;
      add_pkt(s, len, $urandom_range(0, 3), npay, 1'b0);
    end
    drain(20000);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
